// File: rtl/sys_seq_pkg.sv
// Shared definitions for the system-op sequencer: FSM states, machine-mode
// CSR addresses, trap cause codes and the system-op cause encoding.
// Optional build macro: SYS_SEQ_TVAL_EN (adds the mtval write state).
package sys_seq_pkg;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;

    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

    // System-op cause codes as produced by the decode-side classifier.
    localparam logic [4:0] SYSOP_NONE   = 5'd0;
    localparam logic [4:0] SYSOP_ECALL  = 5'd1;
    localparam logic [4:0] SYSOP_EBREAK = 5'd2;
    localparam logic [4:0] SYSOP_RET    = 5'd3;
    localparam logic [4:0] SYSOP_CSR_W  = 5'd4;
    localparam logic [4:0] SYSOP_CSR_S  = 5'd5;
    localparam logic [4:0] SYSOP_CSR_C  = 5'd6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CSR_RD,
        ST_CSR_WR,
        ST_TRAP_EPC,
        ST_TRAP_CAUSE,
`ifdef SYS_SEQ_TVAL_EN
        ST_TRAP_TVAL,
`endif
        ST_TRAP_VEC,
        ST_RET_RD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sys_op_seq_csr_alu.sv
// CSR read-modify-write data path: write data for W/S/C and suppression of
// set/clear writes whose mask is zero.
module sys_csr_alu
    import sys_seq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] wdata,
    output logic            we
);

    // Select write data and write enable from the CSR op kind.
    always_comb begin
        wdata = '0;
        we    = 1'b0;
        case (op)
            SYSOP_CSR_W: begin
                wdata = src;
                we    = 1'b1;
            end
            SYSOP_CSR_S: begin
                wdata = old_val | src;
                we    = |src;
            end
            SYSOP_CSR_C: begin
                wdata = old_val & ~src;
                we    = |src;
            end
            default: begin
                wdata = '0;
                we    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sys_op_seq.sv
// System-op sequencer: drives the single-ported CSR file through CSR
// read-modify-write, trap entry and mret, stalling the pipeline meanwhile.
// Optional build macro: SYS_SEQ_TVAL_EN (trap entry also writes mtval).
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | waiting for a system op, op_ready=1
// CSR_RD      | read target CSR, rd writeback or illegal-CSR trap
// CSR_WR      | write modified CSR value (skipped for zero S/C mask)
// TRAP_EPC    | write mepc with aligned PC
// TRAP_CAUSE  | write mcause
// TRAP_TVAL   | write mtval (only with SYS_SEQ_TVAL_EN)
// TRAP_VEC    | read mtvec, redirect to handler
// RET_RD      | read mepc, redirect for mret
// DONE        | one stall cycle before returning to IDLE
module sys_op_seq
    import sys_seq_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [4:0]        op_cause,
    input  logic [CSR_AW-1:0] op_csr_addr,
    input  logic [XLEN-1:0]   op_src,
    input  logic [XLEN-1:0]   op_pc,
    output logic [CSR_AW-1:0] csr_addr,
    output logic              csr_re,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic              csr_rerr,
    output logic              csr_we,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              rd_we,
    output logic [XLEN-1:0]   rd_wdata,
    output logic              redir_valid,
    output logic [XLEN-1:0]   redir_pc,
    output logic              busy
);

    localparam logic [XLEN-1:0] ALIGN4 = ~XLEN'(3);
    localparam logic [XLEN-1:0] ALIGN2 = ~XLEN'(1);

    state_e            state_q, state_d;
    logic [4:0]        cause_q, cause_d;
    logic [CSR_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [3:0]        tcause_q, tcause_d;
`ifdef SYS_SEQ_TVAL_EN
    logic              tval_csr_q, tval_csr_d;
`endif
    logic              csr_re_q, csr_re_d;
    logic              csr_we_q, csr_we_d;
    logic [CSR_AW-1:0] csr_addr_q, csr_addr_d;
    logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;

    logic [XLEN-1:0]   alu_wdata;
    logic              alu_we;
    logic              op_take;

    sys_csr_alu #(.XLEN(XLEN)) u_alu (
        .op      (cause_q),
        .old_val (csr_rdata),
        .src     (src_q),
        .wdata   (alu_wdata),
        .we      (alu_we)
    );

    assign op_take = op_valid && (op_cause != SYSOP_NONE);

    // Next-state and next CSR-port values; CSR strobes are set up one cycle
    // ahead so the port is driven straight from flops.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        addr_d      = addr_q;
        src_d       = src_q;
        pc_d        = pc_q;
        tcause_d    = tcause_q;
`ifdef SYS_SEQ_TVAL_EN
        tval_csr_d  = tval_csr_q;
`endif
        csr_re_d    = 1'b0;
        csr_we_d    = 1'b0;
        csr_addr_d  = '0;
        csr_wdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (op_take) begin
                    cause_d = op_cause;
                    addr_d  = op_csr_addr;
                    src_d   = op_src;
                    pc_d    = op_pc;
`ifdef SYS_SEQ_TVAL_EN
                    tval_csr_d = 1'b0;
`endif
                    case (op_cause)
                        SYSOP_CSR_W, SYSOP_CSR_S, SYSOP_CSR_C: begin
                            state_d    = ST_CSR_RD;
                            csr_re_d   = 1'b1;
                            csr_addr_d = op_csr_addr;
                        end
                        SYSOP_RET: begin
                            state_d    = ST_RET_RD;
                            csr_re_d   = 1'b1;
                            csr_addr_d = CSR_AW'(CSR_MEPC);
                        end
                        default: begin
                            if (op_cause == SYSOP_ECALL)
                                tcause_d = CAUSE_ECALL_M;
                            else if (op_cause == SYSOP_EBREAK)
                                tcause_d = CAUSE_BREAKPOINT;
                            else
                                tcause_d = CAUSE_ILLEGAL;
                            state_d     = ST_TRAP_EPC;
                            csr_we_d    = 1'b1;
                            csr_addr_d  = CSR_AW'(CSR_MEPC);
                            csr_wdata_d = op_pc & ALIGN4;
                        end
                    endcase
                end
            end
            ST_CSR_RD: begin
                if (csr_rerr) begin
                    tcause_d    = CAUSE_ILLEGAL;
`ifdef SYS_SEQ_TVAL_EN
                    tval_csr_d  = 1'b1;
`endif
                    state_d     = ST_TRAP_EPC;
                    csr_we_d    = 1'b1;
                    csr_addr_d  = CSR_AW'(CSR_MEPC);
                    csr_wdata_d = pc_q & ALIGN4;
                end else begin
                    state_d     = ST_CSR_WR;
                    csr_we_d    = alu_we;
                    csr_addr_d  = addr_q;
                    csr_wdata_d = alu_wdata;
                end
            end
            ST_CSR_WR: state_d = ST_DONE;
            ST_TRAP_EPC: begin
                state_d     = ST_TRAP_CAUSE;
                csr_we_d    = 1'b1;
                csr_addr_d  = CSR_AW'(CSR_MCAUSE);
                csr_wdata_d = {{(XLEN-4){1'b0}}, tcause_q};
            end
            ST_TRAP_CAUSE: begin
`ifdef SYS_SEQ_TVAL_EN
                state_d     = ST_TRAP_TVAL;
                csr_we_d    = 1'b1;
                csr_addr_d  = CSR_AW'(CSR_MTVAL);
                csr_wdata_d = tval_csr_q ? {{(XLEN-CSR_AW){1'b0}}, addr_q} : '0;
            end
            ST_TRAP_TVAL: begin
`endif
                state_d    = ST_TRAP_VEC;
                csr_re_d   = 1'b1;
                csr_addr_d = CSR_AW'(CSR_MTVEC);
            end
            ST_TRAP_VEC: state_d = ST_DONE;
            ST_RET_RD:   state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Sequencer state and latched op; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cause_q     <= '0;
            addr_q      <= '0;
            src_q       <= '0;
            pc_q        <= '0;
            tcause_q    <= '0;
`ifdef SYS_SEQ_TVAL_EN
            tval_csr_q  <= 1'b0;
`endif
            csr_re_q    <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            addr_q      <= addr_d;
            src_q       <= src_d;
            pc_q        <= pc_d;
            tcause_q    <= tcause_d;
`ifdef SYS_SEQ_TVAL_EN
            tval_csr_q  <= tval_csr_d;
`endif
            csr_re_q    <= csr_re_d;
            csr_we_q    <= csr_we_d;
            csr_addr_q  <= csr_addr_d;
            csr_wdata_q <= csr_wdata_d;
        end
    end

    // Read data returns in the same cycle, so writeback and redirect are
    // qualified by the state that owns the read.
    always_comb begin
        op_ready    = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE) || op_take;
        csr_re      = csr_re_q;
        csr_we      = csr_we_q;
        csr_addr    = csr_addr_q;
        csr_wdata   = csr_wdata_q;
        rd_we       = (state_q == ST_CSR_RD) && !csr_rerr;
        rd_wdata    = rd_we ? csr_rdata : '0;
        redir_valid = (state_q == ST_TRAP_VEC) || (state_q == ST_RET_RD);
        redir_pc    = '0;
        if (state_q == ST_TRAP_VEC)
            redir_pc = csr_rdata & ALIGN4;
        else if (state_q == ST_RET_RD)
            redir_pc = csr_rdata & ALIGN2;
    end

endmodule

// File: tb/tb_sys_op_seq.sv
// Directed bench for sys_op_seq with a small CSR-file model.
// Honours SYS_SEQ_TVAL_EN to match the build of the design.
module tb_sys_op_seq;
    import sys_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  op_cause;
    logic [11:0] op_csr_addr;
    logic [63:0] op_src;
    logic [63:0] op_pc;
    logic [11:0] csr_addr;
    logic        csr_re;
    logic [63:0] csr_rdata;
    logic        csr_rerr;
    logic        csr_we;
    logic [63:0] csr_wdata;
    logic        rd_we;
    logic [63:0] rd_wdata;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        busy;

    logic [63:0] v300, v301, vmepc, vmtvec;
    int          we_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          snap;

    sys_op_seq #(.XLEN(64), .CSR_AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_cause(op_cause), .op_csr_addr(op_csr_addr), .op_src(op_src),
        .op_pc(op_pc), .csr_addr(csr_addr), .csr_re(csr_re),
        .csr_rdata(csr_rdata), .csr_rerr(csr_rerr), .csr_we(csr_we),
        .csr_wdata(csr_wdata), .rd_we(rd_we), .rd_wdata(rd_wdata),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        csr_rdata = '0;
        csr_rerr  = 1'b0;
        if (csr_re) begin
            case (csr_addr)
                12'h300: csr_rdata = v300;
                12'h301: csr_rdata = v301;
                12'h341: csr_rdata = vmepc;
                12'h305: csr_rdata = vmtvec;
                12'h7FF: csr_rerr  = 1'b1;
                default: csr_rdata = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (csr_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] c, input logic [11:0] a,
                         input logic [63:0] s, input logic [63:0] pc);
        op_valid    = 1'b1;
        op_cause    = c;
        op_csr_addr = a;
        op_src      = s;
        op_pc       = pc;
        #1;
        chk("busy_at_accept", busy, 1);
        chk("ready_at_accept", op_ready, 1);
        tick();
        op_valid = 1'b0;
        op_cause = '0;
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_cause = '0; op_csr_addr = '0;
        op_src = '0; op_pc = '0;
        v300 = 64'h8; v301 = 64'hFF; vmepc = '0; vmtvec = 64'h8000_0101;
        tick(); tick();
        chk("rst_ready", op_ready, 1);
        chk("rst_we", csr_we, 0);
        chk("rst_re", csr_re, 0);
        chk("rst_redir", redir_valid, 0);
        rst_n = 1'b1;
        tick();

        // cause 0 is ignored
        op_valid = 1'b1; op_cause = 5'd0; #1;
        chk("none_busy", busy, 0);
        tick();
        chk("none_ready", op_ready, 1);
        op_valid = 1'b0;
        tick();

        // CSR_S 0x300: old 0x8 | 0x80
        issue(SYSOP_CSR_S, 12'h300, 64'h80, 64'h0);
        chk("s_rd_we", rd_we, 1);
        chk("s_rd_wdata", rd_wdata, 64'h8);
        chk("s_re", csr_re, 1);
        chk("s_busy1", busy, 1);
        tick();
        chk("s_we", csr_we, 1);
        chk("s_wdata", csr_wdata, 64'h88);
        chk("s_waddr", csr_addr, 12'h300);
        chk("s_rd_we_off", rd_we, 0);
        chk("s_busy2", busy, 1);
        tick();
        chk("s_busy3", busy, 1);
        chk("s_ready_done", op_ready, 0);
        tick();
        chk("s_busy_end", busy, 0);
        chk("s_ready_end", op_ready, 1);

        // CSR_C with zero mask: no write
        snap = we_cnt;
        issue(SYSOP_CSR_C, 12'h301, 64'h0, 64'h0);
        chk("c_rd_wdata", rd_wdata, 64'hFF);
        tick(); tick(); tick();
        chk("c_no_write", 64'(we_cnt - snap), 0);

        // ECALL trap
        snap = we_cnt;
        issue(SYSOP_ECALL, 12'h0, 64'h0, 64'h8000_1002);
        chk("e_epc_we", csr_we, 1);
        chk("e_epc_addr", csr_addr, 12'h341);
        chk("e_epc_data", csr_wdata, 64'h8000_1000);
        tick();
        chk("e_cause_addr", csr_addr, 12'h342);
        chk("e_cause_data", csr_wdata, 64'd11);
        chk("e_redir_early", redir_valid, 0);
        tick();
`ifdef SYS_SEQ_TVAL_EN
        chk("e_tval_addr", csr_addr, 12'h343);
        chk("e_tval_data", csr_wdata, 64'h0);
        tick();
`endif
        chk("e_redir", redir_valid, 1);
        chk("e_redir_pc", redir_pc, 64'h8000_0100);
        chk("e_rd_we", rd_we, 0);
        tick();
        chk("e_redir_pulse", redir_valid, 0);
        tick();
`ifdef SYS_SEQ_TVAL_EN
        chk("e_writes", 64'(we_cnt - snap), 3);
`else
        chk("e_writes", 64'(we_cnt - snap), 2);
`endif

        // CSR_W to nonexistent CSR -> illegal instruction trap
        snap = we_cnt;
        issue(SYSOP_CSR_W, 12'h7FF, 64'h5, 64'h100);
        chk("x_rd_we", rd_we, 0);
        chk("x_re", csr_re, 1);
        tick();
        chk("x_epc_data", csr_wdata, 64'h100);
        tick();
        chk("x_cause_addr", csr_addr, 12'h342);
        chk("x_cause_data", csr_wdata, 64'd2);
        tick();
`ifdef SYS_SEQ_TVAL_EN
        chk("x_tval_addr", csr_addr, 12'h343);
        chk("x_tval_data", csr_wdata, 64'h7FF);
        tick();
`endif
        chk("x_redir", redir_valid, 1);
        tick(); tick();
`ifdef SYS_SEQ_TVAL_EN
        chk("x_writes", 64'(we_cnt - snap), 3);
`else
        chk("x_writes", 64'(we_cnt - snap), 2);
`endif

        // Unknown code -> illegal instruction
        issue(5'd7, 12'h0, 64'h0, 64'h204);
        tick();
        chk("u_cause_data", csr_wdata, 64'd2);
        tick(); tick(); tick();
`ifdef SYS_SEQ_TVAL_EN
        tick();
`endif

        // mret
        vmepc = 64'h8000_2001;
        issue(SYSOP_RET, 12'h0, 64'h0, 64'h0);
        chk("r_redir", redir_valid, 1);
        chk("r_redir_pc", redir_pc, 64'h8000_2000);
        chk("r_rd_we", rd_we, 0);
        tick(); tick();
        chk("r_ready", op_ready, 1);

        // reset during TRAP_CAUSE
        issue(SYSOP_ECALL, 12'h0, 64'h0, 64'h400);
        tick();
        chk("rc_cause_we", csr_we, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rc_ready", op_ready, 1);
        chk("rc_we", csr_we, 0);
        chk("rc_redir", redir_valid, 0);
        snap = we_cnt;
        tick(); tick();
        chk("rc_quiet", 64'(we_cnt - snap), 0);

        issue(SYSOP_EBREAK, 12'h0, 64'h0, 64'h8000_0008);
        chk("b_epc_data", csr_wdata, 64'h8000_0008);
        tick();
        chk("b_cause_data", csr_wdata, 64'd3);
        tick();
`ifdef SYS_SEQ_TVAL_EN
        tick();
`endif
        chk("b_redir", redir_valid, 1);
        chk("b_redir_pc", redir_pc, 64'h8000_0100);
        tick(); tick();
        chk("b_ready", op_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
